// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the async FIFO: handshake, write pointers, status.
// Ports: clk/rst, wr_valid/wr_ready, rq_wptr, clr_ovf -> mem_we, waddr, wptr,
//        full, almost_full, wr_level, overflow.
module fifo_wr_ctrl #(
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PTR_WIDTH-1:0] rq_wptr,
  input  logic                 clr_ovf,
  output logic                 mem_we,
  output logic [PTR_WIDTH-2:0] waddr,
  output logic [PTR_WIDTH-1:0] wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH-1:0] wr_level,
  output logic                 overflow
);

  localparam int MSB = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] AF_T = PTR_WIDTH'(AF_THRESH);

  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] wbin_nxt;
  logic [PTR_WIDTH-1:0] wgray_nxt;
  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] level_nxt;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic                 accept;

  assign wr_ready = ~full & ~rst;
  assign accept   = wr_valid & wr_ready;
  assign mem_we   = accept;
  assign waddr    = wbin[PTR_WIDTH-2:0];

  assign wbin_nxt  = wbin + {{(PTR_WIDTH-1){1'b0}}, accept};
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rbin[i] = ^(rq_wptr >> i);
    end
  end

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp  = {~rq_wptr[MSB -: 2], rq_wptr[MSB-2:0]};
  assign level_nxt = wbin_nxt - rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_nxt;
      wptr        <= wgray_nxt;
      full        <= (wgray_nxt == full_cmp);
      almost_full <= (level_nxt >= AF_T);
      wr_level    <= level_nxt;
      // Set has priority over clear.
      if (wr_valid && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

endmodule
